// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one 64-bit logical-right barrel shifter among NUM_REQ lanes.
// SLL and SRA are built around the single shifter; one registered output stage gives 1-cycle latency.
module shift_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 64,
    parameter int TAG_W = 4,
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_data,
    input  logic [6*NUM_REQ-1:0]     req_shamt,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic [TAG_W-1:0]         resp_tag,
    output logic                     resp_err,
    output logic [31:0]              grant_cnt
);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  winner;
    logic             any_valid;
    logic             can_accept;
    logic             accept;

    logic [1:0]       op_p0;
    logic [WIDTH-1:0] x_p0;
    logic [5:0]       shamt_p0;
    logic [TAG_W-1:0] tag_p0;
    logic             neg_p0;
    logic [WIDTH-1:0] shift_in_p0;
    logic [WIDTH-1:0] shift_out_p0;
    logic [WIDTH-1:0] result_p0;

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [ID_W-1:0]  id_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             err_p1;
    logic [31:0]      cnt_q;

    // Rotating-priority scan: first valid requester at or after the pointer wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                any_valid = 1'b1;
                winner    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign can_accept = !vld_p1 || resp_ready;
    assign accept     = any_valid && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // ---- stage p0: operand select and shift ----
    always_comb begin
        op_p0    = req_op[int'(winner)*2 +: 2];
        x_p0     = req_data[int'(winner)*WIDTH +: WIDTH];
        shamt_p0 = req_shamt[int'(winner)*6 +: 6];
        tag_p0   = req_tag[int'(winner)*TAG_W +: TAG_W];
        neg_p0   = (op_p0 == OP_SRA) && x_p0[WIDTH-1];

        // SLL reflects operand and result; negative SRA complements both so zero-fill becomes sign-fill.
        if (op_p0 == OP_SLL) begin
            shift_in_p0 = bitrev(x_p0);
        end else if (neg_p0) begin
            shift_in_p0 = ~x_p0;
        end else begin
            shift_in_p0 = x_p0;
        end

        shift_out_p0 = shift_in_p0 >> shamt_p0;

        case (op_p0)
            OP_SRL:  result_p0 = shift_out_p0;
            OP_SLL:  result_p0 = bitrev(shift_out_p0);
            OP_SRA:  result_p0 = neg_p0 ? ~shift_out_p0 : shift_out_p0;
            default: result_p0 = '0;
        endcase
    end

    // ---- stage p1: response register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
            tag_p1  <= '0;
            err_p1  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            if (accept) begin
                vld_p1  <= 1'b1;
                data_p1 <= result_p0;
                id_p1   <= winner;
                tag_p1  <= tag_p0;
                err_p1  <= (op_p0 == OP_ILL);
                cnt_q   <= cnt_q + 32'd1;
                ptr_q   <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            end else if (resp_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign resp_valid = vld_p1;
    assign resp_data  = data_p1;
    assign resp_id    = id_p1;
    assign resp_tag   = tag_p1;
    assign resp_err   = err_p1;
    assign grant_cnt  = cnt_q;

endmodule
